adc_frame_buffer: RTL and testbench



---
 rtl/adc_frame_buffer.sv | 146 ++++++++++++++
 tb/tb_adc_frame_buffer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_buffer.sv
// Ping-pong frame buffer between the serial ADC driver and the FFT stage.
// Optional 2:1 pair-averaging decimation is enabled with `define ADC_FRAME_DECIM2_EN.
module adc_frame_buffer #(
    parameter int FRAME_LEN = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_done,
    input  logic [7:0]        adc_data,
    output logic              frm_valid,
    input  logic              frm_ready,
    output logic [7:0]        frm_data,
    output logic [ADDR_W-1:0] frm_index,
    output logic              frm_last,
    output logic              overrun,
    output logic [7:0]        ovf_cnt
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, READ, SEND} rd_state_t;

    logic [7:0]        mem [0:2*FRAME_LEN-1];
    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    rd_state_t         state;

    logic              wr_en;
    logic [7:0]        wr_value;
    logic              frame_done;
    logic              rd_release;
    logic              other_free;

`ifdef ADC_FRAME_DECIM2_EN
    logic       pair_phase;
    logic [7:0] pair_first;
    logic [8:0] pair_sum;

    // Rounded mean of the held odd strobe and the current even strobe.
    assign pair_sum = {1'b0, pair_first} + {1'b0, adc_data} + 9'd1;
    assign wr_en    = adc_done && pair_phase;
    assign wr_value = pair_sum[8:1] ^ 8'h80;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_phase <= 1'b0;
            pair_first <= 8'h00;
        end else if (adc_done) begin
            pair_phase <= ~pair_phase;
            if (!pair_phase) begin
                pair_first <= adc_data;
            end
        end
    end
`else
    assign wr_en    = adc_done;
    assign wr_value = adc_data ^ 8'h80;
`endif

    assign frame_done = wr_en && (wr_ptr == LAST_IDX);
    assign rd_release = (state == SEND) && frm_ready && (rd_ptr == LAST_IDX);
    // A bank drained on this very edge is already usable for the next frame.
    assign other_free = !full[wr_bank ^ 1'b1] || (rd_release && (rd_bank != wr_bank));

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[{wr_bank, wr_ptr}] <= wr_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_ptr  <= '0;
            full    <= 2'b00;
            overrun <= 1'b0;
            ovf_cnt <= 8'h00;
        end else begin
            overrun <= 1'b0;
            if (rd_release) begin
                full[rd_bank] <= 1'b0;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                if (frame_done) begin
                    if (other_free) begin
                        full[wr_bank] <= 1'b1;
                        wr_bank       <= ~wr_bank;
                    end else begin
                        // No free bank: drop this frame and reuse its bank.
                        overrun <= 1'b1;
                        if (ovf_cnt != 8'hFF) begin
                            ovf_cnt <= ovf_cnt + 8'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_bank   <= 1'b0;
            rd_ptr    <= '0;
            frm_valid <= 1'b0;
            frm_data  <= 8'h00;
            frm_index <= '0;
            frm_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        rd_ptr <= '0;
                        state  <= READ;
                    end
                end
                READ: begin
                    frm_data  <= mem[{rd_bank, rd_ptr}];
                    frm_index <= rd_ptr;
                    frm_last  <= (rd_ptr == LAST_IDX);
                    frm_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (frm_ready) begin
                        frm_valid <= 1'b0;
                        if (rd_ptr == LAST_IDX) begin
                            rd_bank <= ~rd_bank;
                            state   <= IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + ADDR_W'(1);
                            state  <= READ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Self-checking bench for adc_frame_buffer: frame-queue reference model plus
// directed ramp, overrun, reset, saturation and random-backpressure scenarios.
`timescale 1ns/1ps
module tb_adc_frame_buffer;

    localparam int FRAME_LEN = 64;
    localparam int ADDR_W    = 6;
`ifdef ADC_FRAME_DECIM2_EN
    localparam int SPS = 2;
`else
    localparam int SPS = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              adc_done = 1'b0;
    logic [7:0]        adc_data = 8'h00;
    logic              frm_ready = 1'b0;
    logic              frm_valid;
    logic [7:0]        frm_data;
    logic [ADDR_W-1:0] frm_index;
    logic              frm_last;
    logic              overrun;
    logic [7:0]        ovf_cnt;

    always #5 clk = ~clk;

    adc_frame_buffer #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .adc_done(adc_done), .adc_data(adc_data),
        .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_data(frm_data),
        .frm_index(frm_index), .frm_last(frm_last), .overrun(overrun), .ovf_cnt(ovf_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: at most one complete frame waits for the consumer
    // while the next one is being captured.
    logic [7:0]        held[$];
    logic [7:0]        part[$];
    int                rd_pos = 0;
    bit                phase = 0;
    logic [7:0]        first_s = 8'h00;
    bit                exp_ovr = 0;
    int                exp_cnt = 0;
    bit                stalled = 0;
    logic [7:0]        s_data;
    logic [ADDR_W-1:0] s_index;
    logic              s_last;
    int                ovr_pulses = 0;
    logic [7:0]        acc_data[$];
    int                acc_index[$];
    bit                acc_last[$];
    logic [7:0]        m_v;
    bit                m_wr;
    int                m_sum;

    always @(negedge clk) begin
        if (rst) begin
            held.delete();
            part.delete();
            rd_pos  = 0;
            phase   = 0;
            exp_ovr = 0;
            exp_cnt = 0;
            stalled = 0;
            check("rst_valid", frm_valid, 0);
            check("rst_ovf_cnt", ovf_cnt, 0);
        end else begin
            check("overrun", overrun, exp_ovr);
            check("ovf_cnt", ovf_cnt, exp_cnt);
            if (overrun) ovr_pulses++;
            exp_ovr = 0;
            if (stalled) begin
                check("stall_valid", frm_valid, 1);
                check("stall_data", frm_data, s_data);
                check("stall_index", frm_index, s_index);
                check("stall_last", frm_last, s_last);
            end
            if (frm_valid) begin
                if (held.size() == 0) begin
                    check("valid_without_frame", frm_valid, 0);
                end else begin
                    check("frm_data", frm_data, held[rd_pos]);
                    check("frm_index", frm_index, rd_pos);
                    check("frm_last", frm_last, (rd_pos == FRAME_LEN - 1));
                    if (frm_ready) begin
                        acc_data.push_back(frm_data);
                        acc_index.push_back(int'(frm_index));
                        acc_last.push_back(frm_last);
                        rd_pos++;
                        if (rd_pos == FRAME_LEN) begin
                            held.delete();
                            rd_pos = 0;
                        end
                    end
                end
            end
            stalled = frm_valid && !frm_ready;
            s_data  = frm_data;
            s_index = frm_index;
            s_last  = frm_last;
            if (adc_done) begin
`ifdef ADC_FRAME_DECIM2_EN
                if (!phase) begin
                    first_s = adc_data;
                    phase   = 1;
                    m_wr    = 0;
                end else begin
                    m_sum = (int'(first_s) + int'(adc_data) + 1) / 2;
                    m_v   = 8'(m_sum) ^ 8'h80;
                    phase = 0;
                    m_wr  = 1;
                end
`else
                m_v  = adc_data ^ 8'h80;
                m_wr = 1;
`endif
                if (m_wr) begin
                    part.push_back(m_v);
                    if (part.size() == FRAME_LEN) begin
                        if (held.size() == 0) begin
                            held = part;
                        end else begin
                            exp_ovr = 1;
                            if (exp_cnt < 255) exp_cnt++;
                        end
                        part.delete();
                    end
                end
            end
        end
    end

    // 0: ready high, 1: ready low, 2: random backpressure
    int ready_mode = 1;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: frm_ready = 1'b1;
            1: frm_ready = 1'b0;
            default: frm_ready = ($urandom_range(3) != 0);
        endcase
    end

    task automatic strobe(input logic [7:0] d, input int gap);
        adc_done = 1'b1;
        adc_data = d;
        @(posedge clk); #1;
        adc_done = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int gap);
        for (int k = 0; k < FRAME_LEN * SPS; k++) strobe(8'($urandom_range(255)), gap);
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while ((held.size() != 0 || frm_valid) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, held.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, frm_valid, 0);
        check({tag, "_data"}, frm_data, 0);
        check({tag, "_index"}, frm_index, 0);
        check({tag, "_last"}, frm_last, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_ovf_cnt"}, ovf_cnt, 0);
    endtask

    task automatic clear_log();
        acc_data.delete();
        acc_index.delete();
        acc_last.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int last_cnt;
        int hit;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        ready_mode = 0;
        @(posedge clk); #1;

        // Ramp frame: latency and literal values
        clear_log();
`ifndef ADC_FRAME_DECIM2_EN
        for (int i = 0; i < FRAME_LEN; i++) strobe(8'(i), (i == FRAME_LEN - 1) ? 0 : 1);
        check("lat_e0_valid", frm_valid, 0);
        @(posedge clk); #1;
        check("lat_e1_valid", frm_valid, 0);
        @(posedge clk); #1;
        check("lat_e2_valid", frm_valid, 1);
        check("ramp_first_data", frm_data, 8'h80);
        check("ramp_first_index", frm_index, 0);
        wait_drain("ramp_drain", 400);
        check("ramp_count", acc_data.size(), FRAME_LEN);
        if (acc_data.size() == FRAME_LEN) begin
            check("ramp_last_data", acc_data[63], 8'hBF);
            check("ramp_last_index", acc_index[63], 63);
            check("ramp_last_flag", acc_last[63], 1);
            last_cnt = 0;
            foreach (acc_last[i]) if (acc_last[i]) last_cnt++;
            check("ramp_last_count", last_cnt, 1);
        end
`else
        for (int i = 0; i < FRAME_LEN; i++) begin
            strobe(8'h10, 1);
            strobe(8'h13, 1);
        end
        wait_drain("decim_drain", 400);
        check("decim_count", acc_data.size(), FRAME_LEN);
        if (acc_data.size() == FRAME_LEN) check("decim_value", acc_data[0], 8'h92);
`endif

        // Overrun: consumer stalled across several frames
        ready_mode = 1;
        ovr_pulses = 0;
        clear_log();
        send_frame(0);
        send_frame(0);
        repeat (3) begin @(posedge clk); #1; end
        check("ovr_cnt_after2", ovf_cnt, 1);
        check("ovr_pulses_after2", ovr_pulses, 1);
        send_frame(0);
        repeat (3) begin @(posedge clk); #1; end
        check("ovr_cnt_after3", ovf_cnt, 2);
        check("ovr_pulses_after3", ovr_pulses, 2);
        ready_mode = 0;
        wait_drain("ovr_drain", 400);
        check("ovr_frames_out", acc_data.size(), FRAME_LEN);

        // Random data with random backpressure
        ready_mode = 2;
        clear_log();
        for (int f = 0; f < 4; f++) send_frame(3);
        wait_drain("rand_drain", 2000);
        check("rand_count", acc_data.size(), 4 * FRAME_LEN);
        check("rand_no_overrun", ovf_cnt, 2);

        // Reset mid-capture, with a strobe during reset
        ready_mode = 0;
        for (int k = 0; k < 30 * SPS; k++) strobe(8'($urandom_range(255)), 1);
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_capture");
        adc_done = 1'b1;
        adc_data = 8'h55;
        @(posedge clk); #1;
        adc_done = 1'b0;
        rst = 1'b0;

        // Reset mid-drain at index 10
        send_frame(0);
        hit = 0;
        for (int n = 0; n < 200 && hit == 0; n++) begin
            @(posedge clk); #1;
            if (frm_valid && frm_index == 10) hit = 1;
        end
        check("reach_index10", hit, 1);
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_drain");
        @(posedge clk); #1;
        rst = 1'b0;
        clear_log();
        send_frame(1);
        wait_drain("clean_drain", 400);
        check("clean_count", acc_data.size(), FRAME_LEN);
        if (acc_index.size() > 0) check("clean_first_index", acc_index[0], 0);

        // Saturation after more than 255 discarded frames
        ready_mode = 1;
        for (int f = 0; f < 302; f++) send_frame(0);
        repeat (3) begin @(posedge clk); #1; end
        check("ovf_saturated", ovf_cnt, 255);
        ready_mode = 0;
        clear_log();
        wait_drain("sat_drain", 400);
        check("sat_frames_out", acc_data.size(), FRAME_LEN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
